// File: rtl/keypad_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner_pkg
//  Brief    : Shared constants, FSM encoding and (row,col)->key lookup for
//             the 3x4 membrane keypad scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_matrix_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = 12;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } scan_state_e;

    // Rows 0..2 carry digits 1..9 in reading order; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_index(input int r, input int c);
        logic [3:0] idx;
        if (r == 3) begin
            case (c)
                0:       idx = 4'(KEY_STAR);
                1:       idx = 4'd0;
                default: idx = 4'(KEY_HASH);
            endcase
        end else begin
            idx = 4'(r * 3 + c + 1);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner_if
//  Brief    : Keypad matrix lines plus the one-hot key/held outputs.
//             master = scanner side, slave = keypad/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_matrix_scanner_if;

    logic [keypad_matrix_scanner_pkg::NUM_ROWS-1:0] row_n;
    logic [keypad_matrix_scanner_pkg::NUM_COLS-1:0] col_n;
    logic [keypad_matrix_scanner_pkg::NUM_KEYS-1:0] key;
    logic                                           held;

    modport master (input row_n, output col_n, output key, output held);
    modport slave  (output row_n, input col_n, input key, input held);

endinterface
`default_nettype wire

// File: rtl/keypad_row_sync.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_row_sync
//  Brief    : 2-flop synchronizer for the asynchronous row lines. Resets to
//             all-ones so every row reads as released.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_row_sync
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int WIDTH = NUM_ROWS
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; meta_q may go metastable, sync_q is clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_matrix_scanner
//  Brief    : Strobes keypad columns, assembles full-scan frames, debounces
//             them and emits a single one-hot key pulse per physical press.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 8,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    keypad_matrix_scanner_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_ROWS-1:0] rows_s;

    keypad_row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.row_n),
        .q_o (row_sync)
    );

    assign rows_s = ~row_sync;

    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    scan_state_e         state_q, state_d;
    logic [3:0]          cand_q, cand_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                held_q, held_d;

    logic                last_dwell;
    logic                frame_end;
    logic [NUM_KEYS-1:0] col_bits;
    logic [NUM_KEYS-1:0] frame_bits;
    logic [3:0]          n_set;
    logic [3:0]          single_idx;
    logic                frame_zero;
    logic                frame_single;

    // Dwell/column sequencing and frame snapshot accumulation.
    always_comb begin
        col_bits   = '0;
        last_dwell = (dwell_q == DWELL_LAST);
        frame_end  = last_dwell && (col_q == 2'd2);
        for (int r = 0; r < NUM_ROWS; r++) begin
            col_bits[key_index(r, int'(col_q))] = rows_s[r];
        end
        frame_bits = snap_q | col_bits;
        dwell_d    = last_dwell ? '0 : dwell_q + DW'(1);
        col_d      = col_q;
        snap_d     = snap_q;
        if (last_dwell) begin
            col_d  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            snap_d = frame_end ? '0 : frame_bits;
        end
        col_n_d = ~(3'b001 << col_d);
    end

    // Classify the completed frame as zero, single key or multi-key.
    always_comb begin
        n_set      = '0;
        single_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n_set = n_set + {3'b000, frame_bits[i]};
            if (frame_bits[i]) begin
                single_idx = 4'(i);
            end
        end
        frame_zero   = (n_set == 4'd0);
        frame_single = (n_set == 4'd1);
    end

    // Debounce FSM; only acts on the frame-end cycle.
    always_comb begin
        logic          accept;
        logic          release_key;
        logic [CW-1:0] cnt_inc;
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = '0;
        held_d      = held_q;
        accept      = 1'b0;
        release_key = 1'b0;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        cand_d  = single_idx;
                        cnt_d   = CNT_ONE;
                        state_d = PRESS_DB;
                        accept  = (CNT_MAX == CNT_ONE);
                    end
                end
                PRESS_DB: begin
                    if (frame_single && single_idx == cand_q) begin
                        cnt_d  = cnt_inc;
                        accept = (cnt_inc == CNT_MAX);
                    end else if (frame_single) begin
                        cand_d = single_idx;
                        cnt_d  = CNT_ONE;
                        accept = (CNT_MAX == CNT_ONE);
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_zero) begin
                        cnt_d       = CNT_ONE;
                        state_d     = REL_DB;
                        release_key = (CNT_MAX == CNT_ONE);
                    end else begin
                        cnt_d = '0;
                    end
                end
                REL_DB: begin
                    if (frame_zero) begin
                        cnt_d       = cnt_inc;
                        release_key = (cnt_inc == CNT_MAX);
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
        if (accept) begin
            key_d[cand_d] = 1'b1;
            held_d        = 1'b1;
            cnt_d         = '0;
            state_d       = HELD;
        end
        if (release_key) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    // State register for scan counters, snapshot and debounce FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            col_q   <= 2'd0;
            col_n_q <= 3'b110;
            snap_q  <= '0;
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
            snap_q  <= snap_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            held_q  <= held_d;
        end
    end

    assign kp.col_n = col_n_q;
    assign kp.key   = key_q;
    assign kp.held  = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_matrix_scanner
//  Brief    : Self-checking bench; models the keypad matrix from col_n and
//             scoreboards expected key pulses against frame numbers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

    logic clk;
    logic rst;

    keypad_matrix_scanner_if kp_if ();

    keypad_matrix_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pressed[r][c]: physical switch state at row r, column c.
    logic [2:0] pressed [4];
    logic [3:0] row_model;

    // Closed switch pulls its row low while its column is strobed.
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r][c] && !kp_if.col_n[c]) begin
                    row_model[r] = 1'b0;
                end
            end
        end
    end

    assign kp_if.row_n = row_model;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] k;
        int          fr;
    } exp_t;

    exp_t sb [$];
    int   frame_cnt = 0;
    logic [2:0] prev_col = 3'b110;

    task automatic push(input logic [11:0] k, input int fr);
        exp_t e;
        e.k  = k;
        e.fr = fr;
        sb.push_back(e);
    endtask

    // Frame tracking and key pulse scoreboard, sampled 1ns after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            prev_col = 3'b110;
        end else begin
            if (prev_col == 3'b011 && kp_if.col_n == 3'b110) begin
                frame_cnt++;
            end
            prev_col = kp_if.col_n;
        end
        if (kp_if.key != 12'h000) begin
            if (sb.size() == 0) begin
                chk("spurious_key", {20'h0, kp_if.key}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("key_val", {20'h0, kp_if.key}, {20'h0, e.k});
                chk("key_frame", frame_cnt, e.fr);
                chk("held_at_key", {31'h0, kp_if.held}, 32'h1);
            end
        end
    end

    task automatic wait_frame(input int target);
        int budget;
        budget = 1000;
        while (frame_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (frame_cnt < target) begin
            chk("frame_timeout", frame_cnt, target);
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    endtask

    logic [2:0] col_exp [3];
    int n;

    initial begin
        col_exp[0] = 3'b110;
        col_exp[1] = 3'b101;
        col_exp[2] = 3'b011;
        clear_keys();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_col_n", {29'h0, kp_if.col_n}, 32'h6);
        chk("rst_key", {20'h0, kp_if.key}, 32'h0);
        chk("rst_held", {31'h0, kp_if.held}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("col_seq", {29'h0, kp_if.col_n}, {29'h0, col_exp[i / 4]});
            @(negedge clk);
        end

        // '5' press and long hold: one pulse only.
        n = frame_cnt;
        pressed[1][1] = 1'b1;
        push(12'h020, n + 3);
        wait_frame(n + 3);
        chk("held_5", {31'h0, kp_if.held}, 32'h1);
        wait_frame(n + 13);
        chk("held_5_long", {31'h0, kp_if.held}, 32'h1);

        // Release '5'.
        n = frame_cnt;
        clear_keys();
        wait_frame(n + 2);
        chk("held_rel_early", {31'h0, kp_if.held}, 32'h1);
        wait_frame(n + 3);
        chk("held_rel_5", {31'h0, kp_if.held}, 32'h0);

        // '0' press, then release.
        n = frame_cnt;
        pressed[3][1] = 1'b1;
        push(12'h001, n + 3);
        wait_frame(n + 3);
        chk("held_0", {31'h0, kp_if.held}, 32'h1);
        n = frame_cnt;
        clear_keys();
        wait_frame(n + 3);
        chk("held_rel_0", {31'h0, kp_if.held}, 32'h0);

        // Bouncing '7' for 4 frames, then stable.
        n = frame_cnt;
        pressed[2][0] = 1'b1;
        wait_frame(n + 1);
        clear_keys();
        wait_frame(n + 2);
        pressed[2][0] = 1'b1;
        wait_frame(n + 3);
        clear_keys();
        wait_frame(n + 4);
        pressed[2][0] = 1'b1;
        push(12'h080, n + 7);
        wait_frame(n + 7);
        chk("held_7", {31'h0, kp_if.held}, 32'h1);
        n = frame_cnt;
        clear_keys();
        wait_frame(n + 3);
        chk("held_rel_7", {31'h0, kp_if.held}, 32'h0);

        // '1'+'2' together rejected; then '1' alone accepted; '#' added ignored.
        n = frame_cnt;
        pressed[0][0] = 1'b1;
        pressed[0][1] = 1'b1;
        wait_frame(n + 4);
        chk("held_multi", {31'h0, kp_if.held}, 32'h0);
        n = frame_cnt;
        pressed[0][1] = 1'b0;
        push(12'h002, n + 3);
        wait_frame(n + 3);
        chk("held_1", {31'h0, kp_if.held}, 32'h1);
        n = frame_cnt;
        pressed[3][2] = 1'b1;
        wait_frame(n + 4);
        chk("held_1_hash", {31'h0, kp_if.held}, 32'h1);
        n = frame_cnt;
        clear_keys();
        wait_frame(n + 3);
        chk("held_rel_1", {31'h0, kp_if.held}, 32'h0);

        // Reset during press debounce (count=2) discards progress.
        n = frame_cnt;
        pressed[2][2] = 1'b1;
        wait_frame(n + 2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_col_n", {29'h0, kp_if.col_n}, 32'h6);
        chk("mid_rst_key", {20'h0, kp_if.key}, 32'h0);
        chk("mid_rst_held", {31'h0, kp_if.held}, 32'h0);
        rst = 1'b0;
        n = frame_cnt;
        push(12'h200, n + 3);
        wait_frame(n + 2);
        chk("held_9_early", {31'h0, kp_if.held}, 32'h0);
        wait_frame(n + 3);
        chk("held_9", {31'h0, kp_if.held}, 32'h1);
        n = frame_cnt;
        clear_keys();
        wait_frame(n + 4);
        chk("held_rel_9", {31'h0, kp_if.held}, 32'h0);

        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives the column strobes of a 3x4 membrane keypad and samples its row lines.
- Debounces the samples and emits the one-cycle, one-hot `key[11:0]` pulse that `keypad_encoder` consumes.
- Producer end of the `key` interface: its `key` output connects directly to `safe_top.key`.
- Rejects multi-key presses and produces exactly one pulse per physical press.

Parameters:
- SCAN_DIV, 8: clock cycles each column stays driven (dwell). Must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-scan frames required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; synchronous, active-high
- row_n  input  4  keypad row lines, active-low, pulled up, asynchronous to clk
- col_n  output  3  column strobes, active-low, exactly one low at any time
- key  output  12  one-hot key pulse, high for one cycle on an accepted press
- held  output  1  high while an accepted key has not yet been debounced as released

Behaviour:
- Reset values (rst high at a clk edge):
  - col_n=3'b110 (column 0 driven); key=0; held=0.
  - Dwell counter, column index, frame snapshot, candidate and debounce count all cleared.
  - FSM enters IDLE.
  - Reset mid-frame or mid-debounce discards all partial state; no pulse is emitted.
- Row synchronizer:
  - row_n passes through a 2-flop synchronizer; rows_s = ~sync(row_n).
  - Latency is 2 cycles.
- Scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle:
    - rows_s is ORed into the frame snapshot bits for the current column.
    - The column index advances 0->1->2->0 and col_n updates the same edge.
  - SCAN_DIV >= 4 guarantees synchronized data from the current column.
  - A frame is 3*SCAN_DIV cycles. Frame end is the sample of column 2.
  - The snapshot clears for the next frame.
- Key index mapping (row r, col c):
  - r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: *,0,#.
  - key[d]=digit d for 0..9; key[10]='*'; key[11]='#'.
- Frame classification:
  - ZERO: no bits set.
  - SINGLE(k): exactly one bit set.
  - MULTI: two or more bits set.
- FSM, evaluated at frame end only:
  - IDLE:
    - SINGLE(k): candidate=k, count=1, go to PRESS_DB. If DEBOUNCE_FRAMES==1, accept immediately.
    - ZERO or MULTI: stay.
  - PRESS_DB:
    - SINGLE(k) with k==candidate: count+1.
    - SINGLE(k) with k!=candidate: candidate=k, count=1.
    - ZERO or MULTI: back to IDLE, count=0.
    - When count reaches DEBOUNCE_FRAMES: key=onehot(candidate) for exactly the next clk cycle, held=1, go to HELD.
  - HELD:
    - Any non-ZERO frame (including MULTI or a different key): count=0, no pulse.
    - ZERO frame: count+1, go to REL_DB.
  - REL_DB:
    - ZERO: count+1.
    - Non-ZERO: back to HELD, count=0.
    - At DEBOUNCE_FRAMES ZERO frames: held=0, go to IDLE.
- Output timing:
  - key is registered and rises the cycle after the accepting frame-end edge.
  - key is zero in every other cycle.
  - held rises in the same cycle as the key pulse and falls the cycle after the final release frame end.
- Holding a key never produces a second pulse; auto-repeat is not supported.
- The debounce counter is $clog2(DEBOUNCE_FRAMES+1) bits and saturates; it never wraps.

Decomposition:
- Shared package:
  - NUM_ROWS=4, NUM_COLS=3, NUM_KEYS=12.
  - KEY_STAR=10, KEY_HASH=11.
  - The (row,col) to key-index lookup.
  - FSM state encoding: IDLE, PRESS_DB, HELD, REL_DB.
- One sub-module is natural: `keypad_row_sync`, the 4-bit 2-flop synchronizer with synchronous reset to all-ones (released).
- Scan counters and FSM stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 cycles; the bench models the matrix from col_n):
- Reset: assert rst 2 cycles -> col_n=110, key=0, held=0. Release rst -> col_n sequence 110,101,011, each for 4 cycles.
- Press '5' (r1,c1) and hold -> key=12'h020 for exactly one cycle after the 3rd qualifying frame end, held=1. No further pulse over 10 more frames.
- Release '5' -> held=0 after 3 ZERO frames. Press '0' -> key=12'h001 once.
- Bounce '7': alternate pressed/released each frame for 4 frames, then hold -> exactly one key=12'h080 pulse, 3 frames after the final stable press.
- Press '1'+'2' together -> no pulse, held=0. Release '2' keeping '1' -> key=12'h002 after 3 frames. Hold '1' and add '#' -> no pulse, held stays 1.
- Assert rst during PRESS_DB count=2 -> no pulse, col_n=110. Keeping the key pressed then requires 3 full new frames before key fires.
